// File: rtl/mem_data_port_arbiter_if.sv
// Bundle for the shared BRAM data port: both master request/response channels
// plus the Memory port-2 pins driven by the arbiter.
interface mem_data_port_arbiter_if;
  logic        req_a, req_b;
  logic        we_a, we_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] din_a, din_b;
  logic [1:0]  size_a, size_b;
  logic        sign_a, sign_b;
  logic        gnt_a, gnt_b;
  logic        rvalid_a, rvalid_b;
  logic [31:0] rdata;
  logic        mem_rden2, mem_we2;
  logic [31:0] mem_addr2, mem_din2;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_dout2;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, din_a, din_b,
           size_a, size_b, sign_a, sign_b, mem_dout2,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata,
           mem_rden2, mem_we2, mem_addr2, mem_din2, mem_size, mem_sign
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, din_a, din_b,
           size_a, size_b, sign_a, sign_b, mem_dout2,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata,
           mem_rden2, mem_we2, mem_addr2, mem_din2, mem_size, mem_sign
  );
endinterface

// File: rtl/mem_data_port_arbiter.sv
// Two-master arbiter for the OTTER BRAM data port; holds address/size/sign
// through the read-data cycle since the Memory extracts read data combinationally.
module mem_data_port_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 8
) (
  input logic clk,
  input logic rst_n,
  mem_data_port_arbiter_if.slave bus
);
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {IDLE, RD_DATA} state_t;

  state_t           state_q, state_d;
  logic             last_b_q, owner_b_q;
  logic [31:0]      addr_q, din_q;
  logic [1:0]       size_q;
  logic             sign_q;
  logic [CNT_W-1:0] wait_q;

  logic             any_req, pick_b, gnt_a, gnt_b;
  logic             sel_we, sel_sign;
  logic [31:0]      sel_addr, sel_din;
  logic [1:0]       sel_size;

  assign any_req = bus.req_a | bus.req_b;

  always_comb begin
    pick_b = bus.req_b;
    if (bus.req_a && bus.req_b) begin
      if (PRIO_MODE == 0) pick_b = ~last_b_q;
      else                pick_b = (wait_q == WAIT_MAX);
    end
  end

  assign sel_we   = pick_b ? bus.we_b   : bus.we_a;
  assign sel_addr = pick_b ? bus.addr_b : bus.addr_a;
  assign sel_din  = pick_b ? bus.din_b  : bus.din_a;
  assign sel_size = pick_b ? bus.size_b : bus.size_a;
  assign sel_sign = pick_b ? bus.sign_b : bus.sign_a;

  // Idle pins hold the last issued access; grants are masked while in reset.
  always_comb begin
    state_d       = state_q;
    gnt_a         = 1'b0;
    gnt_b         = 1'b0;
    bus.mem_rden2 = 1'b0;
    bus.mem_we2   = 1'b0;
    bus.mem_addr2 = addr_q;
    bus.mem_din2  = din_q;
    bus.mem_size  = size_q;
    bus.mem_sign  = sign_q;
    case (state_q)
      IDLE: begin
        if (rst_n && any_req) begin
          gnt_a         = ~pick_b;
          gnt_b         = pick_b;
          bus.mem_we2   = sel_we;
          bus.mem_rden2 = ~sel_we;
          bus.mem_addr2 = sel_addr;
          bus.mem_din2  = sel_din;
          bus.mem_size  = sel_size;
          bus.mem_sign  = sel_sign;
          if (!sel_we) state_d = RD_DATA;
        end
      end
      RD_DATA: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rvalid_a = (state_q == RD_DATA) & ~owner_b_q;
  assign bus.rvalid_b = (state_q == RD_DATA) & owner_b_q;
  assign bus.rdata    = bus.mem_dout2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      size_q    <= '0;
      sign_q    <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_a || gnt_b) begin
        last_b_q  <= gnt_b;
        owner_b_q <= gnt_b;
        addr_q    <= sel_addr;
        din_q     <= sel_din;
        size_q    <= sel_size;
        sign_q    <= sel_sign;
      end
      // B aging: counts while B is kept waiting, saturating at the threshold
      if (gnt_b || !bus.req_b)    wait_q <= '0;
      else if (wait_q != WAIT_MAX) wait_q <= wait_q + 1'b1;
    end
  end
endmodule
